ccff_chain_loader: RTL and testbench

- Drives a configuration-chain: loads a host bitstream serially into the fabric's `ccff_head` and reads the old contents back from `ccff_tail`.
- The chain is the `mux_*_mem` shift-register chain that runs through every connection/switch block. This block is the chain writer.
- Sits between the bitstream host interface (valid/ready word streams) and the fabric's programming port.
- Produces the clock-enable that gates the fabric's `prog_clk`, so the chain shifts only on valid bit cycles.

---
 rtl/ccff_pkg.sv | 20 ++
 rtl/ccff_rb_packer.sv | 66 ++++++
 rtl/ccff_chain_loader.sv | 138 +++++++++++++
 tb/tb_ccff_chain_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and derived-size helpers for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ccff_state_t;

    // Number of host words needed to carry the whole chain.
    function automatic int nwords(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Number of meaningful bits in the final host word.
    function automatic int last_bits(input int chain_len, input int word_w);
        return chain_len - (nwords(chain_len, word_w) - 1) * word_w;
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Readback deserializer: collects ccff_tail bits into words and holds each
// finished word in a valid/ready output register until the host takes it.
module ccff_rb_packer #(
    parameter int WORD_W    = 8,
    parameter int LAST_BITS = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              clear,
    input  logic              capture,
    input  logic              tail_bit,
    input  logic              final_word,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] rx_word;
    logic [WORD_W-1:0] rx_next;
    logic [CNT_W-1:0]  rx_cnt;
    logic              word_full;

    // Merge the incoming tail bit at the current position and detect word end.
    always_comb begin
        rx_next   = rx_word;
        word_full = 1'b0;
        for (int i = 0; i < WORD_W; i++) begin
            if (rx_cnt == CNT_W'(i)) begin
                rx_next[i] = tail_bit;
            end
        end
        if (final_word) begin
            word_full = (rx_cnt == CNT_W'(LAST_BITS - 1));
        end else begin
            word_full = (rx_cnt == CNT_W'(WORD_W - 1));
        end
    end

    // Accumulate bits, then move the finished word into the output register.
    always_ff @(posedge prog_clk) begin
        if (pReset || clear) begin
            rx_word <= '0;
            rx_cnt  <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (capture) begin
                if (word_full) begin
                    m_data  <= rx_next;
                    m_valid <= 1'b1;
                    rx_word <= '0;
                    rx_cnt  <= '0;
                end else begin
                    rx_word <= rx_next;
                    rx_cnt  <= rx_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain writer: shifts a host bitstream into ccff_head while
// returning the previous chain contents from ccff_tail as readback words.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 42,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic              busy,
    output logic              done
);

    localparam int NWORDS    = nwords(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = last_bits(CHAIN_LEN, WORD_W);
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W    = $clog2(NWORDS + 1);
    localparam int TXC_W     = $clog2(WORD_W + 1);

    ccff_state_t       state;
    ccff_state_t       state_next;

    logic [WORD_W-1:0] tx_word;
    logic [TXC_W-1:0]  tx_cnt;
    logic [WCNT_W-1:0] words_in;
    logic [WCNT_W-1:0] words_out;
    logic [BIT_W-1:0]  bit_cnt;

    logic              load_clear;
    logic              shift_en;
    logic              s_accept;
    logic              rx_accept;
    logic              final_in;
    logic              last_out;

    // Handshakes and shift enable, all derived from registered state only.
    always_comb begin
        s_ready     = (state == SHIFT) && (tx_cnt == '0) &&
                      (words_in < WCNT_W'(NWORDS));
        shift_en    = (state == SHIFT) && (tx_cnt != '0) && !m_valid;
        prog_clk_en = shift_en;
        ccff_head   = shift_en & tx_word[0];
        s_accept    = s_ready & s_valid;
        rx_accept   = m_valid & m_ready;
        final_in    = (words_in == WCNT_W'(NWORDS - 1));
        last_out    = (words_out == WCNT_W'(NWORDS - 1));
    end

    // Next-state and status outputs of the load sequencer.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                    load_clear = 1'b1;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if ((bit_cnt == BIT_W'(CHAIN_LEN)) && rx_accept && last_out) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // TX buffer and the word/bit counters; the final word only loads LAST_BITS.
    always_ff @(posedge prog_clk) begin
        if (pReset || load_clear) begin
            tx_word   <= '0;
            tx_cnt    <= '0;
            words_in  <= '0;
            words_out <= '0;
            bit_cnt   <= '0;
        end else begin
            if (s_accept) begin
                tx_word  <= s_data;
                tx_cnt   <= final_in ? TXC_W'(LAST_BITS) : TXC_W'(WORD_W);
                words_in <= words_in + WCNT_W'(1);
            end else if (shift_en) begin
                tx_word <= tx_word >> 1;
                tx_cnt  <= tx_cnt - TXC_W'(1);
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (rx_accept) begin
                words_out <= words_out + WCNT_W'(1);
            end
        end
    end

    ccff_rb_packer #(
        .WORD_W    (WORD_W),
        .LAST_BITS (LAST_BITS)
    ) u_packer (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .clear      (load_clear),
        .capture    (shift_en),
        .tail_bit   (ccff_tail),
        .final_word (last_out),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 42-bit and a 16-bit chain model
// driven by two loader instances sharing the host streams.
`timescale 1ns/1ps
module tb_ccff_chain_loader;

    logic        prog_clk = 1'b0;
    logic        pReset   = 1'b0;
    logic        start42  = 1'b0;
    logic        start16  = 1'b0;
    logic [7:0]  s_data   = 8'h00;
    logic        s_valid  = 1'b0;
    logic        m_ready  = 1'b0;
    logic        sel      = 1'b0;

    logic        s_ready42, m_valid42, head42, en42, busy42, done42, tail42;
    logic [7:0]  m_data42;
    logic        s_ready16, m_valid16, head16, en16, busy16, done16, tail16;
    logic [7:0]  m_data16;

    logic [41:0] chain42 = '0;
    logic [15:0] chain16 = '0;
    int          shifts42 = 0;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  rb [6];
    int          rb_n;
    int          en_n;

    always #5 prog_clk = ~prog_clk;

    assign tail42 = chain42[0];
    assign tail16 = chain16[0];

    wire       mx_s_ready = sel ? s_ready16 : s_ready42;
    wire       mx_m_valid = sel ? m_valid16 : m_valid42;
    wire [7:0] mx_m_data  = sel ? m_data16  : m_data42;
    wire       mx_head    = sel ? head16    : head42;
    wire       mx_en      = sel ? en16      : en42;
    wire       mx_busy    = sel ? busy16    : busy42;
    wire       mx_done    = sel ? done16    : done42;

    ccff_chain_loader #(.CHAIN_LEN(42), .WORD_W(8)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start42),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready42),
        .m_data(m_data42), .m_valid(m_valid42), .m_ready(m_ready),
        .ccff_head(head42), .ccff_tail(tail42), .prog_clk_en(en42),
        .busy(busy42), .done(done42)
    );

    ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
        .prog_clk(prog_clk), .pReset(pReset), .start(start16),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready16),
        .m_data(m_data16), .m_valid(m_valid16), .m_ready(m_ready),
        .ccff_head(head16), .ccff_tail(tail16), .prog_clk_en(en16),
        .busy(busy16), .done(done16)
    );

    // Fabric chains: ccff_head enters the far end, ccff_tail is cell 0.
    always @(posedge prog_clk) begin
        if (en42) begin
            chain42  <= {head42, chain42[41:1]};
            shifts42 <= shifts42 + 1;
        end
        if (en16) begin
            chain16 <= {head16, chain16[15:1]};
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkQuiet(input string pfx);
        checkOutput({pfx, "_s_ready"}, 64'(mx_s_ready), 64'd0);
        checkOutput({pfx, "_m_valid"}, 64'(mx_m_valid), 64'd0);
        checkOutput({pfx, "_m_data"},  64'(mx_m_data),  64'd0);
        checkOutput({pfx, "_head"},    64'(mx_head),    64'd0);
        checkOutput({pfx, "_en"},      64'(mx_en),      64'd0);
        checkOutput({pfx, "_busy"},    64'(mx_busy),    64'd0);
        checkOutput({pfx, "_done"},    64'(mx_done),    64'd0);
    endtask

    task automatic applyStimulus(input logic use16, input logic [7:0] w [6], input logic gaps,
                                 input int stall_at, input int abort_after, input int dup_start_at);
        int          nbits, nw, cyc, wi;
        logic        finished, aborted, stall, have_held, first_seen;
        logic [41:0] snap, exp_chain;
        logic [7:0]  held, tmp, exp_rb;
        sel        = use16;
        nbits      = use16 ? 16 : 42;
        nw         = use16 ? 2 : 6;
        snap       = use16 ? {26'b0, chain16} : chain42;
        rb_n       = 0;
        en_n       = 0;
        wi         = 0;
        cyc        = 0;
        finished   = 1'b0;
        aborted    = 1'b0;
        have_held  = 1'b0;
        first_seen = 1'b0;
        held       = 8'h00;
        for (int k = 0; k < 6; k++) rb[k] = 8'h00;
        @(negedge prog_clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (use16) start16 = 1'b1; else start42 = 1'b1;
        while (!finished && cyc < 800) begin
            @(negedge prog_clk);
            cyc++;
            start42 = 1'b0;
            start16 = 1'b0;
            if (cyc == 1) begin
                checkOutput("start_busy",    64'(mx_busy),    64'd1);
                checkOutput("start_s_ready", 64'(mx_s_ready), 64'd1);
            end
            stall = (stall_at > 0) && (cyc >= stall_at) && (cyc < stall_at + 20);
            if (mx_en) begin
                en_n++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    if (!gaps) checkOutput("first_en_cycle", 64'(cyc), 64'd2);
                end
            end
            if (stall && mx_m_valid) begin
                checkOutput("stall_en_low", 64'(mx_en), 64'd0);
                if (have_held) checkOutput("stall_m_data", 64'(mx_m_data), 64'(held));
                held      = mx_m_data;
                have_held = 1'b1;
            end
            if (mx_done) finished = 1'b1;
            if (cyc == dup_start_at) begin
                if (use16) start16 = 1'b1; else start42 = 1'b1;
            end
            m_ready = !stall;
            if (wi < nw && (!gaps || $urandom_range(0, 2) != 0)) begin
                s_valid = 1'b1;
                s_data  = w[wi];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom_range(0, 255));
            end
            if (mx_m_valid && m_ready && rb_n < 6) begin
                rb[rb_n] = mx_m_data;
                rb_n++;
            end
            if (s_valid && mx_s_ready) wi++;
            if (abort_after > 0 && en_n == abort_after) begin
                pReset   = 1'b1;
                aborted  = 1'b1;
                finished = 1'b1;
            end
        end
        checkOutput("load_finished", 64'(finished), 64'd1);
        if (aborted) begin
            @(negedge prog_clk);
            checkQuiet("abort");
            pReset  = 1'b0;
            s_valid = 1'b0;
        end else begin
            checkOutput("enable_total", 64'(en_n), 64'(nbits));
            checkOutput("words_in",     64'(wi),   64'(nw));
            checkOutput("words_out",    64'(rb_n), 64'(nw));
            exp_chain = '0;
            for (int i = 0; i < nbits; i++) begin
                tmp          = w[i / 8];
                exp_chain[i] = tmp[i % 8];
            end
            checkOutput("chain", use16 ? 64'(chain16) : 64'(chain42), 64'(exp_chain));
            for (int k = 0; k < nw; k++) begin
                exp_rb = 8'h00;
                for (int j = 0; j < 8; j++) begin
                    if (8 * k + j < nbits) exp_rb[j] = snap[8 * k + j];
                end
                checkOutput($sformatf("readback%0d", k), 64'(rb[k]), 64'(exp_rb));
            end
            s_valid = 1'b0;
            @(negedge prog_clk);
            checkOutput("done_width", 64'(mx_done), 64'd0);
            checkOutput("idle_busy",  64'(mx_busy), 64'd0);
        end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0]  w [6];
        logic [7:0]  exp1 [6];
        logic [41:0] prev;
        int          base;

        $display("[TB] reset with random inputs");
        pReset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge prog_clk);
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 8'($urandom_range(0, 255));
            m_ready = 1'($urandom_range(0, 1));
            start42 = (c == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            start16 = (c == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(negedge prog_clk);
        sel = 1'b0; checkQuiet("reset42");
        sel = 1'b1; checkQuiet("reset16");
        sel = 1'b0;
        pReset  = 1'b0;
        start42 = 1'b0;
        start16 = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge prog_clk);
        checkOutput("reset_start_ignored42", 64'(busy42), 64'd0);
        checkOutput("reset_start_ignored16", 64'(busy16), 64'd0);

        $display("[TB] first load into zero chain");
        w = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        applyStimulus(1'b0, w, 1'b0, 0, 0, 0);
        for (int k = 0; k < 6; k++) checkOutput("load1_rb_zero", 64'(rb[k]), 64'd0);
        checkOutput("load1_chain_hand", 64'(chain42), 64'h205_0403_0201);

        $display("[TB] second load of all ones");
        w    = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h02};
        applyStimulus(1'b0, w, 1'b0, 0, 0, 0);
        for (int k = 0; k < 6; k++) checkOutput("load2_rb_hand", 64'(rb[k]), 64'(exp1[k]));
        checkOutput("load2_chain_ones", 64'(chain42), 64'h3FF_FFFF_FFFF);

        $display("[TB] backpressure load");
        w = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'h71, 8'h2B};
        applyStimulus(1'b0, w, 1'b1, 15, 0, 0);

        $display("[TB] reset after shift 17");
        prev = chain42;
        base = shifts42;
        w = '{8'h5A, 8'hC3, 8'h77, 8'h00, 8'hFF, 8'h11};
        applyStimulus(1'b0, w, 1'b0, 0, 17, 0);
        checkOutput("abort_shift_count", 64'(shifts42 - base), 64'd17);
        checkOutput("abort_new_bits",  64'(chain42[41:25]), 64'h1C35A);
        checkOutput("abort_kept_bits", 64'(chain42[24:0]),  64'(prev[41:17]));

        $display("[TB] full reload with start while busy");
        w = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        applyStimulus(1'b0, w, 1'b0, 0, 0, 8);

        $display("[TB] 16-bit chain");
        w = '{8'hC3, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(1'b1, w, 1'b0, 0, 0, 0);
        checkOutput("len16_chain_hand", 64'(chain16), 64'h5EC3);
        checkOutput("len16_rb0_zero", 64'(rb[0]), 64'd0);
        checkOutput("len16_rb1_zero", 64'(rb[1]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
